ucsbece152a_tl_sched: RTL and testbench
=======================================

# ucsbece152a_tl_sched

Timing and arbitration controller for the taillight datapath. It conditions the raw switch inputs (left, right, hazard, brake) and arbitrates them into one active sequence mode. It sequences that mode through a 4-frame step counter advanced by a prescaled tick, and generates the PWM dimmer signal used for runlights. Its outputs drive the pattern/output stage, which maps mode, step and brake to the six lamps.

## Interface
- `TICK_DIV`, default 12500000: clk cycles per sequence step (≥2).
- `PWM_PERIOD`, default 16: dimmer period in clk cycles (≥2).
- `PWM_DUTY`, default 4: high cycles per dimmer period (0..PWM_PERIOD).
- `DB_CYCLES`, default 4: stability window for debounce (≥1).
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `left_i` in 1: raw left-turn switch.
- `right_i` in 1: raw right-turn switch.
- `hazard_i` in 1: raw hazard switch.
- `brake_i` in 1: raw brake switch.
- `mode_o` out 2: active mode (mode_t: IDLE=0, LEFT=1, RIGHT=2, HAZARD=3).
- `step_o` out 2: current frame, 0 = all-off, 1..3 = lamps lit progressively.
- `tick_o` out 1: one-cycle step strobe.
- `brake_o` out 1: conditioned brake.
- `clk_dimmer_o` out 1: registered PWM dimmer.

## Operation
- **Input conditioning.** Each input passes through a 2-flop synchronizer, then a debouncer. The debounced value flips only after the synchronized input has differed from it for DB_CYCLES consecutive cycles. Any glitch restarts the count.
- **Request priority.**
  - hazard, or left and right together → HAZARD.
  - otherwise left → LEFT.
  - otherwise right → RIGHT.
  - otherwise IDLE.
- **Step sequencing** occurs only on cycles where tick fires:
  - step 1→2, 2→3, 3→0, mode unchanged.
  - at step 0, sample the request: if non-IDLE, mode←req and step←1; else mode←IDLE and step←0.
- **Mode latching.** Mode changes only at the step-0 sample. A started sequence always completes through step 3 and its off frame. This holds even if its switch is released or a higher-priority request arrives.
- **Brake.** brake_o is the conditioned brake only. It never affects mode or step.
- **Tick prescaler.** Counter runs 0..TICK_DIV-1 and wraps. tick_o=1 exactly when counter==TICK_DIV-1.
- **PWM.** Counter runs 0..PWM_PERIOD-1 and wraps. clk_dimmer_o registers (cnt < PWM_DUTY).
  - PWM_DUTY=0 → constantly 0.
  - PWM_DUTY=PWM_PERIOD → constantly 1.
- **Counter widths.** $clog2 of the respective maximum; no overflow beyond the wrap value.

## Timing
- **Reset values** (all outputs and state cleared asynchronously on rst_n low):
  - mode_o=IDLE, step_o=0, tick_o=0, brake_o=0, clk_dimmer_o=0.
  - all counters, synchronizers and debounced values 0.
- **Reset mid-sequence** aborts the sequence immediately. After release, the first tick is TICK_DIV cycles later.
- **Input latency.** Raw edge to debounced change takes 2 + DB_CYCLES cycles.
- **Step/mode update.** mode_o and step_o update on the clk edge ending the tick_o cycle and are visible the cycle after tick_o.
- **Request-to-mode latency** from IDLE: up to one tick period. From an active sequence: up to four tick periods, because the current sequence finishes first.
- **Request timing at the sample tick.** A request that becomes valid in the same cycle as the step-0 tick is taken. A request withdrawn before that cycle is not.
- **PWM output.** clk_dimmer_o is one cycle behind the PWM counter compare.

## Configuration
- **`TL_SCHED_DEBOUNCE_EN` defined:** debouncers are instantiated as above. Input latency is 2 + DB_CYCLES.
- **`TL_SCHED_DEBOUNCE_EN` undefined:** the synchronizer output is used directly. Input latency is 2 cycles and DB_CYCLES is ignored.

## Structure
- **Package `ucsbece152a_tl_pkg`:**
  - `mode_t` enum (2-bit).
  - step constants STEP_OFF=0 and STEP_LAST=3.
  - shared by this block and the pattern/output stage.
- **Sub-module `ucsbece152a_tl_debounce`:**
  - synchronizer plus stability counter, instantiated four times.
  - contains the `TL_SCHED_DEBOUNCE_EN` conditional.

## Test plan
Bench parameters for all scenarios: TICK_DIV=4, PWM_PERIOD=8, PWM_DUTY=2, DB_CYCLES=3.
- **Reset.** Hold rst_n=0 for 5 cycles, then release → all outputs 0. First tick_o occurs on the 4th cycle after release, then every 4 cycles.
- **Left sequence.** left_i=1 held steady → mode_o=LEFT. step_o follows 1,2,3,0,1… changing one cycle after each tick_o. Drop left_i during step 2 → steps 3,0 still occur, then mode_o=IDLE, step_o=0.
- **Preemption deferral.** During LEFT step 1, assert hazard_i → mode_o stays LEFT through steps 2,3,0. HAZARD is entered at the next step-0 tick with step_o=1.
- **Left and right together.** left_i=right_i=1 from IDLE → mode_o=HAZARD.
- **Debounce.**
  - 2-cycle pulse on brake_i → brake_o stays 0.
  - 6-cycle pulse → brake_o rises 5 cycles after the rising edge.
  - with `TL_SCHED_DEBOUNCE_EN` undefined → 2-cycle pulse appears on brake_o after 2 cycles.
- **PWM.** Free-run → clk_dimmer_o pattern 1,1,0,0,0,0,0,0 repeating. PWM_DUTY=0 gives constant 0; PWM_DUTY=8 gives constant 1.

Source files
------------

// File: rtl/ucsbece152a_tl_pkg.sv
// rtl/ucsbece152a_tl_pkg.sv - shared taillight mode/step types for scheduler and pattern stage
package ucsbece152a_tl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } mode_t;

    localparam logic [1:0] STEP_OFF  = 2'd0;
    localparam logic [1:0] STEP_LAST = 2'd3;

    // Simultaneous left+right is treated as a hazard request.
    function automatic mode_t arbitrate(input logic hazard, input logic left, input logic right);
        mode_t m;
        if (hazard || (left && right)) begin
            m = HAZARD;
        end else if (left) begin
            m = LEFT;
        end else if (right) begin
            m = RIGHT;
        end else begin
            m = IDLE;
        end
        return m;
    endfunction

endpackage

// File: rtl/ucsbece152a_tl_debounce.sv
// rtl/ucsbece152a_tl_debounce.sv - 2-flop synchronizer plus optional stability debouncer (TL_SCHED_DEBOUNCE_EN)
module ucsbece152a_tl_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], din};
        end
    end

`ifdef TL_SCHED_DEBOUNCE_EN
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Count consecutive disagreeing cycles; any agreement restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (sync[1] != dout) begin
            if (cnt == CNT_MAX) begin
                dout <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end
`else
    logic unused_db;

    assign dout      = sync[1];
    assign unused_db = ^DB_CYCLES;
`endif

endmodule

// File: rtl/ucsbece152a_tl_sched.sv
// rtl/ucsbece152a_tl_sched.sv - taillight input arbitration, step sequencer, tick prescaler and PWM dimmer
module ucsbece152a_tl_sched
    import ucsbece152a_tl_pkg::*;
#(
    parameter int TICK_DIV   = 12500000,
    parameter int PWM_PERIOD = 16,
    parameter int PWM_DUTY   = 4,
    parameter int DB_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       left_i,
    input  logic       right_i,
    input  logic       hazard_i,
    input  logic       brake_i,
    output logic [1:0] mode_o,
    output logic [1:0] step_o,
    output logic       tick_o,
    output logic       brake_o,
    output logic       clk_dimmer_o
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int PW = $clog2(PWM_PERIOD);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PWM_MAX  = PW'(PWM_PERIOD - 1);

    logic          left, right, hazard;
    logic [TW-1:0] tick_cnt;
    logic [PW-1:0] pwm_cnt;
    logic [1:0]    step;
    mode_t         mode;
    mode_t         req;

    ucsbece152a_tl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_left (
        .clk(clk), .rst_n(rst_n), .din(left_i), .dout(left));
    ucsbece152a_tl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_right (
        .clk(clk), .rst_n(rst_n), .din(right_i), .dout(right));
    ucsbece152a_tl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_hazard (
        .clk(clk), .rst_n(rst_n), .din(hazard_i), .dout(hazard));
    ucsbece152a_tl_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_brake (
        .clk(clk), .rst_n(rst_n), .din(brake_i), .dout(brake_o));

    assign req    = arbitrate(hazard, left, right);
    assign tick_o = (tick_cnt == TICK_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_o ? '0 : tick_cnt + TW'(1);
        end
    end

    // Mode is only re-sampled at the off frame, so a started sequence always runs to completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= IDLE;
            step <= STEP_OFF;
        end else if (tick_o) begin
            if (step == STEP_OFF) begin
                mode <= req;
                step <= (req != IDLE) ? 2'd1 : STEP_OFF;
            end else if (step == STEP_LAST) begin
                step <= STEP_OFF;
            end else begin
                step <= step + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt      <= '0;
            clk_dimmer_o <= 1'b0;
        end else begin
            pwm_cnt      <= (pwm_cnt == PWM_MAX) ? '0 : pwm_cnt + PW'(1);
            clk_dimmer_o <= (int'(pwm_cnt) < PWM_DUTY);
        end
    end

    assign mode_o = mode;
    assign step_o = step;

endmodule

// File: tb/tb_ucsbece152a_tl_sched.sv
// tb/tb_ucsbece152a_tl_sched.sv - self-checking bench for ucsbece152a_tl_sched (honours TL_SCHED_DEBOUNCE_EN)
module tb_ucsbece152a_tl_sched;

    localparam int TD = 4;
    localparam int PP = 8;
    localparam int PD = 2;
    localparam int DB = 3;
`ifdef TL_SCHED_DEBOUNCE_EN
    localparam bit DBEN = 1'b1;
`else
    localparam bit DBEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic left_i = 1'b0, right_i = 1'b0, hazard_i = 1'b0, brake_i = 1'b0;
    logic [1:0] mode_o, step_o, mode_a, step_a, mode_b, step_b;
    logic tick_o, brake_o, clk_dimmer_o;
    logic tick_a, brake_a, dim_a, tick_b, brake_b, dim_b;

    int n_checks = 0;
    int n_fail = 0;

    ucsbece152a_tl_sched #(.TICK_DIV(TD), .PWM_PERIOD(PP), .PWM_DUTY(PD), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .left_i(left_i), .right_i(right_i), .hazard_i(hazard_i),
        .brake_i(brake_i), .mode_o(mode_o), .step_o(step_o), .tick_o(tick_o),
        .brake_o(brake_o), .clk_dimmer_o(clk_dimmer_o));

    ucsbece152a_tl_sched #(.TICK_DIV(TD), .PWM_PERIOD(PP), .PWM_DUTY(0), .DB_CYCLES(DB)) dut_d0 (
        .clk(clk), .rst_n(rst_n), .left_i(left_i), .right_i(right_i), .hazard_i(hazard_i),
        .brake_i(brake_i), .mode_o(mode_a), .step_o(step_a), .tick_o(tick_a),
        .brake_o(brake_a), .clk_dimmer_o(dim_a));

    ucsbece152a_tl_sched #(.TICK_DIV(TD), .PWM_PERIOD(PP), .PWM_DUTY(PP), .DB_CYCLES(DB)) dut_d8 (
        .clk(clk), .rst_n(rst_n), .left_i(left_i), .right_i(right_i), .hazard_i(hazard_i),
        .brake_i(brake_i), .mode_o(mode_b), .step_o(step_b), .tick_o(tick_b),
        .brake_o(brake_b), .clk_dimmer_o(dim_b));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: conditioned inputs defined by a stable window of raw samples,
    // tick/PWM phases derived from the cycle count since reset release.
    int m_mode = 0, m_step = 0, cyc = 0;
    bit m_tick = 0, m_dim0 = 0, m_dim2 = 0, m_dim8 = 0;
    bit m_cond [4] = '{0, 0, 0, 0};
    logic [3:0] hist [$];

    function automatic int prio(input bit l, input bit r, input bit h);
        if (h || (l && r)) return 3;
        if (l) return 1;
        if (r) return 2;
        return 0;
    endfunction

    function automatic bit dim_of(input int c, input int duty);
        return (c % PP) < duty;
    endfunction

    function automatic bit hs(input int idx, input int b);
        if (idx < 0) return 1'b0;
        return hist[idx][b];
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode = 0; m_step = 0; cyc = 0; m_tick = 0;
                m_dim0 = 0; m_dim2 = 0; m_dim8 = 0;
                for (int b = 0; b < 4; b++) m_cond[b] = 0;
                hist.delete();
            end else begin
                if (m_tick) begin
                    if (m_step == 0) begin
                        m_mode = prio(m_cond[0], m_cond[1], m_cond[2]);
                        m_step = (m_mode != 0) ? 1 : 0;
                    end else begin
                        m_step = (m_step + 1) % 4;
                    end
                end
                m_dim0 = dim_of(cyc, 0);
                m_dim2 = dim_of(cyc, PD);
                m_dim8 = dim_of(cyc, PP);
                cyc++;
                m_tick = ((cyc % TD) == TD - 1);
                hist.push_back({brake_i, hazard_i, right_i, left_i});
                for (int b = 0; b < 4; b++) begin
                    int n;
                    bit r, same;
                    n = hist.size();
                    if (DBEN) begin
                        r = hs(n - 3, b);
                        same = 1'b1;
                        for (int q = n - 2 - DB; q <= n - 3; q++)
                            if (hs(q, b) != r) same = 1'b0;
                        if (same) m_cond[b] = r;
                    end else begin
                        m_cond[b] = hs(n - 2, b);
                    end
                end
                if (hist.size() > 16) void'(hist.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("mode", mode_o, m_mode);
            chk("step", step_o, m_step);
            chk("tick", tick_o, m_tick);
            chk("brake", brake_o, m_cond[3]);
            chk("dimmer", clk_dimmer_o, m_dim2);
            chk("dimmer_duty0", dim_a, m_dim0);
            chk("dimmer_duty8", dim_b, m_dim8);
        end
    end

    task automatic wait_mode(input int m, input int lim);
        int k = 0;
        while (mode_o != 2'(m) && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("wait_mode", mode_o, m);
    endtask

    task automatic wait_tick();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tick_o && k < 12);
        chk("tick_seen", tick_o, 1);
    endtask

    task automatic tick_then(input string nm, input int m, input int s);
        wait_tick();
        @(negedge clk);
        chk({nm, "_mode"}, mode_o, m);
        chk({nm, "_step"}, step_o, s);
    endtask

    task automatic brake_pulse(input int w);
        int lo, hi;
        bit e;
        if (DBEN) begin lo = DB + 2; hi = (w >= DB) ? w + DB + 1 : -1; end
        else begin lo = 2; hi = w + 1; end
        @(posedge clk); #1;
        brake_i = 1'b1;
        for (int j = 0; j < w + 10; j++) begin
            @(negedge clk);
            e = (j >= lo) && (j <= hi);
            chk("brake_pulse", brake_o, e);
            @(posedge clk); #1;
            if (j + 1 == w) brake_i = 1'b0;
        end
    endtask

    logic [9:0] dim_exp;

    initial begin
        dim_exp = 10'b10_0000_0110;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_mode", mode_o, 0);
        chk("rst_step", step_o, 0);
        chk("rst_tick", tick_o, 0);
        chk("rst_dimmer", clk_dimmer_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            chk("post_rst_tick", tick_o, (j % 4 == 0) ? 1 : 0);
            chk("post_rst_dimmer", clk_dimmer_o, dim_exp[j-1]);
        end

        left_i = 1'b1;
        wait_mode(1, 20);
        chk("left_first_step", step_o, 1);
        tick_then("left_s2", 1, 2);
        left_i = 1'b0;
        tick_then("left_s3", 1, 3);
        tick_then("left_s0", 1, 0);
        tick_then("left_idle", 0, 0);

        left_i = 1'b1;
        wait_mode(1, 20);
        chk("pre_step1", step_o, 1);
        hazard_i = 1'b1;
        tick_then("pre_s2", 1, 2);
        tick_then("pre_s3", 1, 3);
        tick_then("pre_s0", 1, 0);
        tick_then("pre_haz", 3, 1);
        left_i = 1'b0;
        hazard_i = 1'b0;
        tick_then("haz_s2", 3, 2);
        tick_then("haz_s3", 3, 3);
        tick_then("haz_s0", 3, 0);
        tick_then("haz_idle", 0, 0);

        left_i = 1'b1;
        right_i = 1'b1;
        wait_mode(3, 20);
        chk("lr_step", step_o, 1);
        left_i = 1'b0;
        right_i = 1'b0;
        repeat (4) wait_tick();
        @(negedge clk);
        chk("lr_idle", mode_o, 0);

        brake_pulse(2);
        brake_pulse(6);

        left_i = 1'b1;
        wait_mode(1, 20);
        wait_tick();
        @(negedge clk);
        chk("mid_step2", step_o, 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        left_i = 1'b0;
        #1;
        chk("mid_rst_mode", mode_o, 0);
        chk("mid_rst_step", step_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            chk("mid_rel_tick", tick_o, (j % 4 == 0) ? 1 : 0);
            chk("mid_rel_mode", mode_o, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
